axi_lite_reg_bank: RTL

- Parametrised AXI4-Lite slave register bank; successor to the fixed 4-register simple_reg.
- Generalised in register count and data width.
- Adds per-register read-only status inputs, self-clearing pulse registers, byte strobes, SLVERR on illegal access, and per-register write strobes.
- Sits behind the block-design AXI interconnect as the control/status port of WATCHMAN firmware blocks.

---
 rtl/axi_lite_reg_bank.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/axi_lite_reg_bank.sv
// AXI4-Lite slave register bank: parametrised register count and width, read-only
// status registers, self-clearing pulse registers, byte strobes, SLVERR and write strobes.
module axi_lite_reg_bank #(
  parameter int unsigned         C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned         NUM_REGS           = 16,
  parameter int unsigned         C_S_AXI_ADDR_WIDTH = 8,
  parameter logic [NUM_REGS-1:0] RO_MASK            = '0,
  parameter logic [NUM_REGS-1:0] PULSE_MASK         = '0
) (
  input  logic                                   ACLK,
  input  logic                                   ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_AWADDR,
  input  logic [2:0]                             S_AXI_AWPROT,
  input  logic                                   S_AXI_AWVALID,
  output logic                                   S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
  input  logic                                   S_AXI_WVALID,
  output logic                                   S_AXI_WREADY,
  output logic [1:0]                             S_AXI_BRESP,
  output logic                                   S_AXI_BVALID,
  input  logic                                   S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_ARADDR,
  input  logic [2:0]                             S_AXI_ARPROT,
  input  logic                                   S_AXI_ARVALID,
  output logic                                   S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_RDATA,
  output logic [1:0]                             S_AXI_RRESP,
  output logic                                   S_AXI_RVALID,
  input  logic                                   S_AXI_RREADY,
  output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_out,
  input  logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_in,
  output logic [NUM_REGS-1:0]                    wr_pulse
);

  localparam int unsigned DW       = C_S_AXI_DATA_WIDTH;
  localparam int unsigned STRB_W   = DW / 8;
  localparam int unsigned ADDR_LSB = $clog2(STRB_W);
  localparam int unsigned IDX_W    = C_S_AXI_ADDR_WIDTH - ADDR_LSB;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic { W_IDLE, W_RESP } wstate_t;
  typedef enum logic { R_IDLE, R_DATA } rstate_t;

  wstate_t                       r_wstate;
  rstate_t                       r_rstate;
  logic [NUM_REGS*DW-1:0]        r_regs;
  logic [NUM_REGS-1:0]           r_wr_pulse;
  logic                          r_awready, r_wready, r_bvalid;
  logic [1:0]                    r_bresp;
  logic                          r_aw_have, r_w_have;
  logic [C_S_AXI_ADDR_WIDTH-1:0] r_aw_addr;
  logic [DW-1:0]                 r_w_data;
  logic [STRB_W-1:0]             r_w_strb;
  logic                          r_arready, r_rvalid;
  logic [1:0]                    r_rresp;
  logic [DW-1:0]                 r_rdata;

  logic                          w_aw_hs, w_w_hs, w_ar_hs;
  logic                          w_aw_avail, w_w_avail, w_commit;
  logic [C_S_AXI_ADDR_WIDTH-1:0] w_waddr;
  logic [DW-1:0]                 w_wdata;
  logic [STRB_W-1:0]             w_wstrb;
  logic [IDX_W-1:0]              w_widx, w_ridx;
  logic [NUM_REGS-1:0]           w_wsel;
  logic                          w_wr_ok, w_rd_ok;
  logic [DW-1:0]                 w_rdata;
  logic [NUM_REGS*DW-1:0]        w_regs_nxt;
  logic                          w_unused;

  assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, w_waddr[ADDR_LSB-1:0],
                      S_AXI_ARADDR[ADDR_LSB-1:0]};

  // Write channel merge: a half already latched takes priority over the live bus.
  always_comb begin
    w_aw_hs    = S_AXI_AWVALID & r_awready;
    w_w_hs     = S_AXI_WVALID & r_wready;
    w_aw_avail = r_aw_have | w_aw_hs;
    w_w_avail  = r_w_have | w_w_hs;
    w_commit   = (r_wstate == W_IDLE) & w_aw_avail & w_w_avail;
    w_waddr    = r_aw_have ? r_aw_addr : S_AXI_AWADDR;
    w_wdata    = r_w_have ? r_w_data : S_AXI_WDATA;
    w_wstrb    = r_w_have ? r_w_strb : S_AXI_WSTRB;
    w_widx     = w_waddr[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB];
    w_wsel     = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (32'(w_widx) == i && !RO_MASK[i]) w_wsel[i] = 1'b1;
    end
    w_wr_ok = |w_wsel;
  end

  // Next register image: pulse registers fall back to zero unless written this cycle.
  always_comb begin
    w_regs_nxt = r_regs;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (PULSE_MASK[i]) w_regs_nxt[i*DW +: DW] = '0;
      if (w_commit && w_wsel[i]) begin
        for (int unsigned b = 0; b < STRB_W; b++) begin
          if (w_wstrb[b]) w_regs_nxt[i*DW + 8*b +: 8] = w_wdata[8*b +: 8];
        end
      end
    end
  end

  // Read mux; out-of-range indices leave data at zero.
  always_comb begin
    w_ar_hs = S_AXI_ARVALID & r_arready;
    w_ridx  = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB];
    w_rd_ok = 1'b0;
    w_rdata = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (32'(w_ridx) == i) begin
        w_rd_ok = 1'b1;
        w_rdata = RO_MASK[i] ? reg_in[i*DW +: DW] : r_regs[i*DW +: DW];
      end
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_wstate   <= W_IDLE;
      r_regs     <= '0;
      r_wr_pulse <= '0;
      r_awready  <= 1'b0;
      r_wready   <= 1'b0;
      r_bvalid   <= 1'b0;
      r_bresp    <= RESP_OKAY;
      r_aw_have  <= 1'b0;
      r_w_have   <= 1'b0;
      r_aw_addr  <= '0;
      r_w_data   <= '0;
      r_w_strb   <= '0;
    end else begin
      r_regs     <= w_regs_nxt;
      r_wr_pulse <= w_commit ? w_wsel : '0;
      case (r_wstate)
        W_IDLE: begin
          if (w_commit) begin
            r_wstate  <= W_RESP;
            r_bvalid  <= 1'b1;
            r_bresp   <= w_wr_ok ? RESP_OKAY : RESP_SLVERR;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_aw_have <= 1'b0;
            r_w_have  <= 1'b0;
          end else begin
            if (w_aw_hs) begin
              r_aw_have <= 1'b1;
              r_aw_addr <= S_AXI_AWADDR;
            end
            if (w_w_hs) begin
              r_w_have <= 1'b1;
              r_w_data <= S_AXI_WDATA;
              r_w_strb <= S_AXI_WSTRB;
            end
            r_awready <= !w_aw_avail;
            r_wready  <= !w_w_avail;
          end
        end
        W_RESP: begin
          if (S_AXI_BREADY) begin
            r_wstate  <= W_IDLE;
            r_bvalid  <= 1'b0;
            r_awready <= 1'b1;
            r_wready  <= 1'b1;
          end
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  // Read FSM; data is captured at the address handshake and held until accepted.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rresp   <= RESP_OKAY;
      r_rdata   <= '0;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          if (w_ar_hs) begin
            r_rstate  <= R_DATA;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b1;
            r_rdata   <= w_rdata;
            r_rresp   <= w_rd_ok ? RESP_OKAY : RESP_SLVERR;
          end else begin
            r_arready <= 1'b1;
          end
        end
        R_DATA: begin
          if (S_AXI_RREADY) begin
            r_rstate  <= R_IDLE;
            r_rvalid  <= 1'b0;
            r_arready <= 1'b1;
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  assign S_AXI_AWREADY = r_awready;
  assign S_AXI_WREADY  = r_wready;
  assign S_AXI_BVALID  = r_bvalid;
  assign S_AXI_BRESP   = r_bresp;
  assign S_AXI_ARREADY = r_arready;
  assign S_AXI_RVALID  = r_rvalid;
  assign S_AXI_RRESP   = r_rresp;
  assign S_AXI_RDATA   = r_rdata;
  assign reg_out       = r_regs;
  assign wr_pulse      = r_wr_pulse;

endmodule
